pc_gen: RTL and testbench

- Sequential next-PC generator for the single-issue MIPS-style core; successor to the combinational next-PC selector.
- Holds the architectural PC register and a parametrised return-address stack (RAS).
- Adds stall, exception entry/return and an EPC register to the sequential/branch/jump selection.
- Feeds the instruction-fetch address; takes redirect controls from the decode stage.

---
 rtl/pc_gen_if.sv | 37 +++
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Redirect/fetch bundle between decode and the next-PC generator.
// Addresses are word addresses, i.e. byte address bits [ADDR_W-1:2].
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    localparam int PC_W = ADDR_W - 2;

    logic            stall;
    logic            branch;
    logic            zero;
    logic [PC_W-1:0] br_offset;
    logic            jump;
    logic            link;
    logic [25:0]     j_target;
    logic            jr;
    logic            ret;
    logic [PC_W-1:0] jr_target;
    logic            exc;
    logic            eret;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] epc;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output stall, branch, zero, br_offset, jump, link, j_target,
               jr, ret, jr_target, exc, eret,
        input  pc, npc, epc, ras_empty, ras_full
    );

    modport slave (
        input  stall, branch, zero, br_offset, jump, link, j_target,
               jr, ret, jr_target, exc, eret,
        output pc, npc, epc, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen.sv
// Sequential next-PC generator: architectural PC, EPC and a circular
// return-address stack, with exception/eret/stall/jump/return/branch selection.
module pc_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int PC_W  = ADDR_W - 2;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  RESET_WORD = RESET_PC[ADDR_W-1:2];
    localparam logic [PC_W-1:0]  EXC_WORD   = EXC_VEC[ADDR_W-1:2];
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  epc_q;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PC_W-1:0]  npc_d;
    logic [PC_W-1:0]  pc_plus_1;
    logic [PC_W-1:0]  br_addr;
    logic [PC_W-1:0]  j_addr;
    logic [PC_W-1:0]  ras_top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_en;
    logic             push;
    logic             pop;

    assign pc_plus_1 = pc_q + PC_W'(1);
    assign br_addr   = pc_plus_1 + bus.br_offset;
    assign j_addr    = {pc_q[PC_W-1:26], bus.j_target};
    assign ras_top   = ras_q[top_q];
    assign top_inc   = top_q + PTR_W'(1);
    assign top_dec   = top_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);

    // Exceptions, erets and stalls freeze the stack; jump outranks jr.
    assign ras_en = !bus.exc && !bus.eret && !bus.stall;
    assign push   = ras_en && bus.jump && bus.link;
    assign pop    = ras_en && !bus.jump && bus.jr && bus.ret && !ras_empty;

    // NOTE: npc_d gets a default before the priority chain so no latch is inferred.
    always_comb begin
        npc_d = pc_plus_1;
        if (bus.exc)                             npc_d = EXC_WORD;
        else if (bus.eret)                       npc_d = epc_q;
        else if (bus.stall)                      npc_d = pc_q;
        else if (bus.jump)                       npc_d = j_addr;
        else if (bus.jr && bus.ret && !ras_empty) npc_d = ras_top;
        else if (bus.jr)                         npc_d = bus.jr_target;
        else if (bus.branch && bus.zero)         npc_d = br_addr;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_WORD;
            epc_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
            // NOTE: the stack array is reset too, so a stale read can never carry X.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q <= npc_d;
            if (bus.exc) begin
                epc_q <= pc_q;
            end
            // When full, top+1 is the oldest slot, so a push overwrites it.
            if (push) begin
                ras_q[top_inc] <= pc_plus_1;
                top_q          <= top_inc;
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                top_q <= top_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.npc       = npc_d;
    assign bus.epc       = epc_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random redirects,
// compared against a queue-based behavioural model of PC, EPC and the RAS.
module tb_pc_gen;
    localparam int ADDR_W    = 32;
    localparam int PC_W      = ADDR_W - 2;
    localparam int RAS_DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_WORD = 30'h0000_0C00;
    localparam logic [PC_W-1:0] EXC_WORD   = 30'h0000_1060;

    typedef struct packed {
        logic            rst;
        logic            stall;
        logic            branch;
        logic            zero;
        logic [PC_W-1:0] br_offset;
        logic            jump;
        logic            link;
        logic [25:0]     j_target;
        logic            jr;
        logic            ret;
        logic [PC_W-1:0] jr_target;
        logic            exc;
        logic            eret;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

    pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: PC, EPC and the RAS as a bounded LIFO (back = top).
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_epc;
    logic [PC_W-1:0] m_ras [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic logic [PC_W-1:0] model_npc(input ctl_t c);
        if (c.exc)                                  return EXC_WORD;
        if (c.eret)                                 return m_epc;
        if (c.stall)                                return m_pc;
        if (c.jump)                                 return {m_pc[PC_W-1:26], c.j_target};
        if (c.jr && c.ret && m_ras.size() > 0)      return m_ras[$];
        if (c.jr)                                   return c.jr_target;
        if (c.branch && c.zero)                     return m_pc + 1 + c.br_offset;
        return m_pc + 1;
    endfunction

    task automatic model_reset();
        m_pc  = RESET_WORD;
        m_epc = '0;
        m_ras.delete();
    endtask

    task automatic model_step(input ctl_t c);
        logic [PC_W-1:0] nxt;
        if (c.rst) begin
            model_reset();
            return;
        end
        nxt = model_npc(c);
        if (!c.exc && !c.eret && !c.stall) begin
            if (c.jump) begin
                if (c.link) begin
                    m_ras.push_back(m_pc + 1);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end
            end else if (c.jr && c.ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        if (c.exc) m_epc = m_pc;
        m_pc = nxt;
    endtask

    // Called just after a rising edge: drive, check on the falling edge, clock, update model.
    task automatic apply(input ctl_t c);
        rst           = c.rst;
        bus.stall     = c.stall;
        bus.branch    = c.branch;
        bus.zero      = c.zero;
        bus.br_offset = c.br_offset;
        bus.jump      = c.jump;
        bus.link      = c.link;
        bus.j_target  = c.j_target;
        bus.jr        = c.jr;
        bus.ret       = c.ret;
        bus.jr_target = c.jr_target;
        bus.exc       = c.exc;
        bus.eret      = c.eret;
        @(negedge clk);
        if (!c.rst) chk("npc", 32'(bus.npc), 32'(model_npc(c)));
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("epc", 32'(bus.epc), 32'(m_epc));
        chk("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
        chk("ras_full", 32'(bus.ras_full), 32'(m_ras.size() == RAS_DEPTH));
        @(posedge clk);
        model_step(c);
        #1;
    endtask

    task automatic do_jump(input logic [25:0] tgt, input logic lnk);
        ctl_t c = idle();
        c.jump = 1'b1;
        c.link = lnk;
        c.j_target = tgt;
        apply(c);
    endtask

    task automatic do_ret(input logic [PC_W-1:0] tgt);
        ctl_t c = idle();
        c.jr = 1'b1;
        c.ret = 1'b1;
        c.jr_target = tgt;
        apply(c);
    endtask

    initial begin
        ctl_t c;

        rst = 1'b1;
        {bus.stall, bus.branch, bus.zero, bus.jump, bus.link, bus.jr, bus.ret,
         bus.exc, bus.eret} = '0;
        bus.br_offset = '0;
        bus.j_target  = '0;
        bus.jr_target = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state and sequential fetch
        chk("reset_pc", 32'(bus.pc), 32'h0000_0C00);
        chk("reset_epc", 32'(bus.epc), 32'h0);
        chk("reset_empty", 32'(bus.ras_empty), 32'h1);
        chk("reset_full", 32'(bus.ras_full), 32'h0);
        repeat (3) apply(idle());
        chk("seq_pc", 32'(bus.pc), 32'h0000_0C03);

        // Branch taken and not taken
        do_jump(26'h0C10, 1'b0);
        c = idle();
        c.branch = 1'b1;
        c.zero = 1'b1;
        c.br_offset = -30'sd2;
        apply(c);
        chk("br_taken", 32'(bus.pc), 32'h0000_0C0F);
        do_jump(26'h0C10, 1'b0);
        c.zero = 1'b0;
        apply(c);
        chk("br_not_taken", 32'(bus.pc), 32'h0000_0C11);

        // Call and return
        do_jump(26'h0C20, 1'b0);
        do_jump(26'h0001000, 1'b1);
        chk("jal_pc", 32'(bus.pc), 32'h0000_1000);
        chk("jal_not_empty", 32'(bus.ras_empty), 32'h0);
        do_ret(30'h555);
        chk("ret_pc", 32'(bus.pc), 32'h0000_0C21);
        chk("ret_empty", 32'(bus.ras_empty), 32'h1);

        // Overflow: five calls into a four-deep stack, then drain past empty
        for (int i = 0; i < 5; i++) do_jump(26'(32'h2000 + 32'h10 * i), 1'b1);
        chk("ovf_full", 32'(bus.ras_full), 32'h1);
        do_ret(30'h777);
        chk("ovf_ret0", 32'(bus.pc), 32'h0000_2031);
        for (int i = 0; i < 3; i++) do_ret(30'h777);
        chk("ovf_ret3", 32'(bus.pc), 32'h0000_2001);
        chk("ovf_drained", 32'(bus.ras_empty), 32'h1);
        do_ret(30'h777);
        chk("ovf_fallback", 32'(bus.pc), 32'h0000_0777);

        // Exception entry under stall, return, and exc+eret together
        do_jump(26'h0C40, 1'b0);
        c = idle();
        c.stall = 1'b1;
        c.exc = 1'b1;
        apply(c);
        chk("exc_pc", 32'(bus.pc), 32'h0000_1060);
        chk("exc_epc", 32'(bus.epc), 32'h0000_0C40);
        c = idle();
        c.eret = 1'b1;
        apply(c);
        chk("eret_pc", 32'(bus.pc), 32'h0000_0C40);
        c.exc = 1'b1;
        apply(c);
        chk("exc_eret_pc", 32'(bus.pc), 32'h0000_1060);
        chk("exc_eret_epc", 32'(bus.epc), 32'h0000_0C40);

        // Stalled call, PC wrap, reset during a call
        do_jump(26'h0ABC, 1'b0);
        c = idle();
        c.stall = 1'b1;
        c.jump = 1'b1;
        c.link = 1'b1;
        c.j_target = 26'h1234;
        repeat (3) apply(c);
        chk("stall_pc", 32'(bus.pc), 32'h0000_0ABC);
        chk("stall_ras", 32'(bus.ras_empty), 32'h1);
        c = idle();
        c.jr = 1'b1;
        c.jr_target = 30'h3FFF_FFFF;
        apply(c);
        apply(idle());
        chk("wrap_pc", 32'(bus.pc), 32'h0);
        do_jump(26'h0100, 1'b1);
        c = idle();
        c.rst = 1'b1;
        c.jump = 1'b1;
        c.link = 1'b1;
        c.exc = 1'b1;
        apply(c);
        chk("rst_pc", 32'(bus.pc), 32'h0000_0C00);
        chk("rst_ras", 32'(bus.ras_empty), 32'h1);
        chk("rst_epc", 32'(bus.epc), 32'h0);

        // Random redirect traffic
        for (int n = 0; n < 3000; n++) begin
            c = idle();
            c.rst       = ($urandom_range(0, 199) == 0);
            c.stall     = ($urandom_range(0, 7) == 0);
            c.exc       = ($urandom_range(0, 24) == 0);
            c.eret      = ($urandom_range(0, 24) == 0);
            c.jump      = ($urandom_range(0, 3) == 0);
            c.link      = ($urandom_range(0, 1) == 0);
            c.jr        = ($urandom_range(0, 3) == 0);
            c.ret       = ($urandom_range(0, 3) != 0);
            c.branch    = ($urandom_range(0, 2) == 0);
            c.zero      = ($urandom_range(0, 1) == 0);
            c.br_offset = PC_W'($signed($urandom_range(0, 63)) - 32);
            c.j_target  = 26'($urandom);
            c.jr_target = PC_W'($urandom);
            apply(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
